adc_rpi_fifo: RTL and testbench

ADC_RPI_FIFO -- requirements
Module: adc_rpi_fifo

---
 rtl/adc_rpi_fifo.sv | 147 ++++++++++++++
 tb/tb_adc_rpi_fifo.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_rpi_fifo.sv
// ============================================================================
//  Module   : adc_rpi_fifo
//  Purpose  : ADC sample FIFO drained by a Raspberry Pi over a ready/read
//             handshake. Optional test pattern: ADC_RPI_FIFO_TPAT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_rpi_fifo #(
    parameter int DEPTH = 1024,
    parameter int DW    = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    input  logic [DW-1:0]            wr_data,
    input  logic                     read,
    output logic                     ready,
    output logic [DW-1:0]            data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    output logic [7:0]               led
);

    localparam int         AW           = $clog2(DEPTH);
    localparam logic [AW:0] C_FULL_LEVEL = (AW+1)'(DEPTH);

    localparam logic [1:0] S_WAIT_LOW = 2'd0;
    localparam logic [1:0] S_IDLE     = 2'd1;
    localparam logic [1:0] S_FETCH    = 2'd2;
    localparam logic [1:0] S_PRESENT  = 2'd3;

    logic            read_meta_q, read_s_q;
    logic            wr_valid_q;
    logic [DW-1:0]   wr_word;
    logic [DW-1:0]   mem [DEPTH];
    logic [DW-1:0]   mem_rdata_q;
    logic [DW-1:0]   data_q;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     level_q, level_d;
    logic            ovf_q;
    logic [1:0]      state_q, state_d;
    logic            wr_acc, rd_en, load;

    // Synchroniser is deliberately not reset: a read held high across reset
    // must still be seen so WAIT_LOW blocks a new handshake.
    always_ff @(posedge clk) begin
        read_meta_q <= read;
        read_s_q    <= read_meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) wr_valid_q <= 1'b0;
        else     wr_valid_q <= wr_valid;
    end

`ifdef ADC_RPI_FIFO_TPAT_EN
    logic [DW-1:0] tpat_q;
    logic          unused_wr_data;

    assign unused_wr_data = ^wr_data;

    always_ff @(posedge clk) begin
        if (rst)         tpat_q <= '0;
        else if (wr_acc) tpat_q <= tpat_q + DW'(1);
    end

    assign wr_word = tpat_q;
`else
    logic [DW-1:0] wr_data_q;

    always_ff @(posedge clk) begin
        wr_data_q <= wr_data;
    end

    assign wr_word = wr_data_q;
`endif

    assign empty  = (level_q == '0);
    assign full   = (level_q == C_FULL_LEVEL);
    assign wr_acc = wr_valid_q & ~full;

    always_comb begin
        level_d = level_q;
        case ({wr_acc, rd_en})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_acc)             wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_en)              rd_ptr_q <= rd_ptr_q + AW'(1);
            if (wr_valid_q && full) ovf_q    <= 1'b1;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr_q] <= wr_word;
        if (rd_en)  mem_rdata_q   <= mem[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_WAIT_LOW;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT_LOW: if (!read_s_q) state_d = S_IDLE;
            S_IDLE:     if (!empty)    state_d = S_FETCH;
            S_FETCH:                   state_d = S_PRESENT;
            S_PRESENT:  if (read_s_q)  state_d = S_WAIT_LOW;
            default:                   state_d = S_WAIT_LOW;
        endcase
    end

    always_comb begin
        ready = (state_q == S_PRESENT);
        rd_en = (state_q == S_IDLE) && !empty;
        load  = (state_q == S_FETCH);
    end

    always_ff @(posedge clk) begin
        if (rst)       data_q <= '0;
        else if (load) data_q <= mem_rdata_q;
    end

    assign data  = data_q;
    assign level = level_q;
    assign ovf   = ovf_q;
    assign led   = {ovf_q, full, empty, ready, level_q[AW-1 -: 4]};

endmodule

`default_nettype wire

// File: tb/tb_adc_rpi_fifo.sv
// ============================================================================
//  Module   : tb_adc_rpi_fifo
//  Purpose  : Directed scoreboard bench for adc_rpi_fifo with an RPi model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adc_rpi_fifo;

    localparam int DEPTH = 1024;
    localparam int DW    = 12;
    localparam int AW    = 10;
`ifdef ADC_RPI_FIFO_TPAT_EN
    localparam int N_STREAM = 4100;
`else
    localparam int N_STREAM = 3000;
`endif

    logic          clk = 1'b0;
    logic          rst, wr_valid, read;
    logic [DW-1:0] wr_data;
    logic          ready, empty, full, ovf;
    logic [DW-1:0] data;
    logic [AW:0]   level;
    logic [7:0]    led;

    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] tpat_m;
    logic [DW-1:0] last;
    bit            rpi_auto, rpi_busy;
    int            rx_count;

    adc_rpi_fifo #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data),
        .read(read), .ready(ready), .data(data), .empty(empty), .full(full),
        .level(level), .ovf(ovf), .led(led)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic [DW-1:0] v);
`ifdef ADC_RPI_FIFO_TPAT_EN
        exp_q.push_back(tpat_m);
        tpat_m = tpat_m + DW'(1);
`else
        exp_q.push_back(v);
`endif
    endtask

    // One clock: inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
        wr_valid = 1'b0;
        if (rpi_auto) begin
            if (!rpi_busy && ready) begin
                check("rpi_word_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("rpi_data", 32'(data), 32'(exp_q.pop_front()));
                rx_count++;
                read     = 1'b1;
                rpi_busy = 1'b1;
            end else if (rpi_busy && !ready) begin
                read     = 1'b0;
                rpi_busy = 1'b0;
            end
        end
    endtask

    task automatic wr(input logic [DW-1:0] v, input bit acc);
        wr_data  = v;
        wr_valid = 1'b1;
        if (acc) push_exp(v);
        tick();
    endtask

    task automatic wait_ready(input logic val, input int budget, input string tag);
        int n = 0;
        while (ready !== val && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(ready), 32'(val));
    endtask

    task automatic drain(input int budget);
        int n = 0;
        rpi_auto = 1'b1;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_done", exp_q.size(), 0);
        repeat (12) tick();
        rpi_auto = 1'b0;
    endtask

    task automatic do_reset();
        read = 1'b0;
        rst  = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        exp_q.delete();
        tpat_m   = '0;
        rpi_busy = 1'b0;
        repeat (5) tick();
    endtask

    initial begin
        int  k;
        int  prev;
        bit  mono, done, phase;

        rst = 1'b1; read = 1'b0; wr_valid = 1'b1; wr_data = 12'hABC;
        rpi_auto = 1'b0; rpi_busy = 1'b0; tpat_m = '0; rx_count = 0;
        repeat (4) @(negedge clk);
        check("rst_ready", 32'(ready), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_level", 32'(level), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_data", 32'(data), 0);
        check("rst_led", 32'(led), 32'h20);
        wr_valid = 1'b0;
        rst      = 1'b0;
        repeat (5) tick();
        check("wr_in_rst_ignored_empty", 32'(empty), 1);
        check("wr_in_rst_ignored_level", 32'(level), 0);

        // Single word latency and handshake
        wr(12'h5A3, 1'b1);
        tick();
        tick();
        check("ready_not_before_w3", 32'(ready), 0);
        tick();
        check("ready_at_w3", 32'(ready), 1);
        last = exp_q.pop_front();
        check("first_data", 32'(data), 32'(last));
        check("first_level", 32'(level), 0);
        read = 1'b1;
        repeat (3) tick();
        check("ready_drop_3clk", 32'(ready), 0);
        check("data_hold_after_read", 32'(data), 32'(last));
        read = 1'b0;
        repeat (6) tick();

        // Fill to capacity, then overflow
        for (int i = 0; i < DEPTH; i++) wr(DW'(i), 1'b1);
        repeat (3) tick();
        check("fill_level", 32'(level), DEPTH - 1);
        check("fill_full", 32'(full), 0);
        check("fill_ready", 32'(ready), 1);
        check("fill_data", 32'(data), 32'(exp_q[0]));
        wr(DW'(DEPTH), 1'b1);
        repeat (2) tick();
        check("full_level", 32'(level), DEPTH);
        check("full_flag", 32'(full), 1);
        wr(DW'(DEPTH + 1), 1'b0);
        repeat (2) tick();
        check("ovf_set", 32'(ovf), 1);
        check("ovf_level_kept", 32'(level), DEPTH);
        check("ovf_led", 32'(led), 32'hD0);
        drain(20000);
        check("ovf_sticky", 32'(ovf), 1);
        check("drained_empty", 32'(empty), 1);
        do_reset();
        check("ovf_cleared", 32'(ovf), 0);

        // Streaming across pointer wrap
        rx_count = 0;
        rpi_auto = 1'b1;
        for (int i = 0; i < N_STREAM; i++) begin
            wr(DW'($urandom), 1'b1);
            repeat (11) tick();
        end
        drain(20000);
        check("stream_count", rx_count, N_STREAM);
        check("stream_no_ovf", 32'(ovf), 0);

        // Simultaneous write and pop keeps level
        for (int i = 0; i < 6; i++) wr(DW'(12'h100 + i), 1'b1);
        repeat (4) tick();
        check("lvl5_level", 32'(level), 5);
        check("lvl5_ready", 32'(ready), 1);
        last = exp_q.pop_front();
        check("lvl5_data", 32'(data), 32'(last));
        read = 1'b1; phase = 1'b0; done = 1'b0; mono = 1'b1; k = 0;
        prev = int'(level);
        for (int c = 0; c < 40 && !done; c++) begin
            wr(DW'(12'h200 + c), 1'b1);
            k++;
            if (int'(level) < prev) mono = 1'b0;
            prev = int'(level);
            if (!phase && !ready) begin
                read  = 1'b0;
                phase = 1'b1;
            end else if (phase && ready) begin
                done = 1'b1;
            end
        end
        check("wrpop_handshake_done", 32'(done), 1);
        check("wrpop_level_never_drops", 32'(mono), 1);
        repeat (2) tick();
        check("wrpop_level", 32'(level), 4 + k);
        last = exp_q.pop_front();
        check("wrpop_data", 32'(data), 32'(last));

        // Reset while presenting with read high
        read = 1'b1;
        tick();
        check("pre_rst_ready", 32'(ready), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_ready", 32'(ready), 0);
        check("midrst_empty", 32'(empty), 1);
        check("midrst_level", 32'(level), 0);
        exp_q.delete();
        tpat_m = '0;
        repeat (4) tick();
        wr(12'h3C5, 1'b1);
        repeat (6) tick();
        check("blocked_while_read_high", 32'(ready), 0);
        check("blocked_level", 32'(level), 1);
        read = 1'b0;
        wait_ready(1'b1, 20, "post_rst_present");
        last = exp_q.pop_front();
        check("post_rst_data", 32'(data), 32'(last));
        check("post_rst_level", 32'(level), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
